// File: rtl/branch_train_queue_if.sv
// rtl/branch_train_queue_if.sv - predictor/resolve/training bundle for branch_train_queue
// Purpose: groups the predict, resolve and training-side signals of the queue.
// Ports (signals):
//   pred_valid/pred_ready/pred_pc/pred_taken/pred_conf  predict-side handshake
//   resolve_valid/resolve_pc/resolve_taken/flush        resolve side
//   train_en/train_pc/actual_taken                      training output
//   history_update_en/branch_taken/mispredict           history output
//   count/err_sticky/mispredict_cnt                     status
// Modports: master drives predict/resolve inputs, slave is the queue.
interface branch_train_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pred_valid;
    logic          pred_ready;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [15:0]   pred_conf;
    logic          resolve_valid;
    logic [31:0]   resolve_pc;
    logic          resolve_taken;
    logic          flush;
    logic          train_en;
    logic [31:0]   train_pc;
    logic          actual_taken;
    logic          history_update_en;
    logic          branch_taken;
    logic          mispredict;
    logic [CW-1:0] count;
    logic [1:0]    err_sticky;
    logic [15:0]   mispredict_cnt;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_conf,
        output resolve_valid, resolve_pc, resolve_taken, flush,
        input  pred_ready, train_en, train_pc, actual_taken,
        input  history_update_en, branch_taken, mispredict,
        input  count, err_sticky, mispredict_cnt
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_conf,
        input  resolve_valid, resolve_pc, resolve_taken, flush,
        output pred_ready, train_en, train_pc, actual_taken,
        output history_update_en, branch_taken, mispredict,
        output count, err_sticky, mispredict_cnt
    );
endinterface

// File: rtl/branch_train_queue.sv
// rtl/branch_train_queue.sv - in-flight branch prediction queue driving predictor training
// Purpose: holds predictions in FIFO order until their branch resolves, then
// issues history-update, mispredict and filtered training pulses.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      branch_train_queue_if.slave (predict, resolve, training, status)
module branch_train_queue #(
    parameter int DEPTH              = 8,
    parameter int TRAINING_THRESHOLD = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    branch_train_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pc    [DEPTH];
    logic          r_taken [DEPTH];
    logic [15:0]   r_conf  [DEPTH];

    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    logic          r_train_en;
    logic [31:0]   r_train_pc;
    logic          r_actual_taken;
    logic          r_hist_en;
    logic          r_branch_taken;
    logic          r_mispredict;
    logic [1:0]    r_err;
    logic [15:0]   r_misp_cnt;

    logic          w_ready;
    logic          w_enq;
    logic          w_deq;
    logic          w_pc_ok;
    logic          w_good;
    logic [31:0]   w_head_pc;
    logic          w_head_taken;
    logic [15:0]   w_head_conf;
    logic [15:0]   w_abs;
    logic          w_low_conf;
    logic          w_misp;
    logic          w_train;

    assign w_ready      = (r_count < CW'(DEPTH));
    // Predictions arriving with a flush belong to the squashed path.
    assign w_enq        = bus.pred_valid && w_ready && !bus.flush;
    assign w_deq        = bus.resolve_valid && (r_count != '0);

    assign w_head_pc    = r_pc[r_rd];
    assign w_head_taken = r_taken[r_rd];
    assign w_head_conf  = r_conf[r_rd];

    assign w_pc_ok      = (bus.resolve_pc == w_head_pc);
    assign w_good       = w_deq && w_pc_ok;

    // Magnitude of the signed dot product; the most negative value has no
    // positive twin in 16 bits so it clamps to the largest positive one.
    assign w_abs = !w_head_conf[15]         ? w_head_conf :
                   (w_head_conf == 16'h8000) ? 16'h7FFF :
                                               (~w_head_conf + 16'd1);

    assign w_low_conf   = (w_abs < 16'(TRAINING_THRESHOLD));
    assign w_misp       = (w_head_taken != bus.resolve_taken);
    assign w_train      = w_misp || w_low_conf;

    // Payload storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_pc[r_wr]    <= bus.pred_pc;
            r_taken[r_wr] <= bus.pred_taken;
            r_conf[r_wr]  <= bus.pred_conf;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            // The resolve in this cycle is still consumed (trained below);
            // every remaining entry is then squashed.
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_deq) begin
                r_rd <= r_rd + PW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_train_en     <= 1'b0;
            r_train_pc     <= '0;
            r_actual_taken <= 1'b0;
            r_hist_en      <= 1'b0;
            r_branch_taken <= 1'b0;
            r_mispredict   <= 1'b0;
            r_err          <= '0;
            r_misp_cnt     <= '0;
        end else begin
            r_train_en   <= 1'b0;
            r_hist_en    <= 1'b0;
            r_mispredict <= 1'b0;

            if (bus.resolve_valid && (r_count == '0)) begin
                r_err[0] <= 1'b1;
            end
            // A PC mismatch still pops the head so the queue stays aligned
            // with program order, but nothing is reported to the predictor.
            if (w_deq && !w_pc_ok) begin
                r_err[1] <= 1'b1;
            end

            if (w_good) begin
                r_hist_en      <= 1'b1;
                r_branch_taken <= bus.resolve_taken;
                r_mispredict   <= w_misp;
                r_train_en     <= w_train;
                if (w_train) begin
                    r_train_pc     <= w_head_pc;
                    r_actual_taken <= bus.resolve_taken;
                end
                if (w_misp && (r_misp_cnt != 16'hFFFF)) begin
                    r_misp_cnt <= r_misp_cnt + 16'd1;
                end
            end
        end
    end

    assign bus.pred_ready        = w_ready;
    assign bus.count             = r_count;
    assign bus.train_en          = r_train_en;
    assign bus.train_pc          = r_train_pc;
    assign bus.actual_taken      = r_actual_taken;
    assign bus.history_update_en = r_hist_en;
    assign bus.branch_taken      = r_branch_taken;
    assign bus.mispredict        = r_mispredict;
    assign bus.err_sticky        = r_err;
    assign bus.mispredict_cnt    = r_misp_cnt;
endmodule
